switch_debouncer: RTL and testbench

//  Conditions the raw slide-switch pins before they reach the switches PIO of the platform.
//  Per bit: 2-flop synchroniser, then a stability-count debouncer.

---
 rtl/switch_debouncer_if.sv | 35 +++
 rtl/switch_debouncer.sv | 82 ++++++++
 tb/tb_switch_debouncer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/switch_debouncer_if.sv
// Switch-conditioning signal bundle: raw pins in, debounced levels, edge pulses and
// the sticky change flag with its acknowledge out.
interface switch_debouncer_if #(
  parameter int WIDTH = 5
);
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_clean;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic [WIDTH-1:0] event_mask;
  logic             change_pending;
  logic             change_ack;

  // Consumer side: supplies the pins and the acknowledge, observes everything else.
  modport master (
    output sw_raw,
    output change_ack,
    input  sw_clean,
    input  sw_rise,
    input  sw_fall,
    input  event_mask,
    input  change_pending
  );

  // Debouncer side.
  modport slave (
    input  sw_raw,
    input  change_ack,
    output sw_clean,
    output sw_rise,
    output sw_fall,
    output event_mask,
    output change_pending
  );
endinterface

// File: rtl/switch_debouncer.sv
// Per-bit 2-flop synchroniser plus stability-count debouncer, with registered
// rise/fall pulses and a sticky, acknowledgeable change flag.
module switch_debouncer #(
  parameter int WIDTH         = 5,
  parameter int STABLE_CYCLES = 500000
) (
  input  logic               clk_clk,
  input  logic               reset_reset,
  switch_debouncer_if.slave  sw_if
);
  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] clean_q, clean_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             pending_q, pending_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  always_comb begin
    sync1_d = sw_if.sw_raw;
    sync2_d = sync1_q;
    clean_d = clean_q;
    rise_d  = '0;
    fall_d  = '0;
    cnt_d   = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      // One cycle of agreement with the current clean level restarts the count.
      if (sync2_q[i] == clean_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        clean_d[i] = sync2_q[i];
        cnt_d[i]   = '0;
        rise_d[i]  = sync2_q[i];
        fall_d[i]  = ~sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
    // change_pending/change_ack: pending stays high until acked; an edge landing in
    // the ack cycle re-sets its bit, so no event is ever lost.
    mask_d    = (mask_q & ~{WIDTH{sw_if.change_ack}}) | rise_d | fall_d;
    pending_d = |mask_d;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      clean_q   <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      mask_q    <= '0;
      pending_q <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      clean_q   <= clean_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      mask_q    <= mask_d;
      pending_q <= pending_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign sw_if.sw_clean       = clean_q;
  assign sw_if.sw_rise        = rise_q;
  assign sw_if.sw_fall        = fall_q;
  assign sw_if.event_mask     = mask_q;
  assign sw_if.change_pending = pending_q;
endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer: directed table, hand-written corner
// sequences and randomized pin activity, all compared against a window-based model.
module tb_switch_debouncer;
  localparam int W = 5;
  localparam int S = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  switch_debouncer_if #(.WIDTH(W)) sw_if ();

  switch_debouncer #(.WIDTH(W), .STABLE_CYCLES(S)) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .sw_if       (sw_if)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // A level is accepted once the synchronised pin has disagreed with the clean level
  // on each of the last S edges since the last reset or accepted change.
  logic [W-1:0] m_s1 = '0, m_s2 = '0, m_clean = '0;
  logic [W-1:0] m_rise = '0, m_fall = '0, m_mask = '0;
  logic         m_pend = 1'b0;
  logic [W-1:0] hist_q[$];
  int           start_idx [W];

  always @(posedge clk) begin : model
    logic [W-1:0] nxt;
    int           n;
    bit           all_diff;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_clean = '0;
      m_rise = '0; m_fall = '0; m_mask = '0; m_pend = 1'b0;
      hist_q.delete();
      for (int i = 0; i < W; i++) start_idx[i] = 0;
    end else begin
      hist_q.push_back(m_s2);
      nxt = m_clean;
      for (int i = 0; i < W; i++) begin
        n = hist_q.size() - start_idx[i];
        if (n >= S) begin
          all_diff = 1'b1;
          for (int k = hist_q.size() - S; k < hist_q.size(); k++)
            if (hist_q[k][i] == m_clean[i]) all_diff = 1'b0;
          if (all_diff) begin
            nxt[i] = ~m_clean[i];
            start_idx[i] = hist_q.size();
          end
        end
      end
      m_rise  = nxt & ~m_clean;
      m_fall  = ~nxt & m_clean;
      m_mask  = (m_mask & ~{W{sw_if.change_ack}}) | m_rise | m_fall;
      m_pend  = |m_mask;
      m_clean = nxt;
      m_s2    = m_s1;
      m_s1    = sw_if.sw_raw;
      if (hist_q.size() > 64) begin
        void'(hist_q.pop_front());
        for (int i = 0; i < W; i++) if (start_idx[i] > 0) start_idx[i]--;
      end
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Inputs change at the falling edge; outputs are checked at the next falling edge.
  task automatic tick(input logic [W-1:0] raw, input logic ack, input logic r);
    sw_if.sw_raw     = raw;
    sw_if.change_ack = ack;
    rst              = r;
    @(posedge clk);
    @(negedge clk);
    chk("model_clean", 32'(sw_if.sw_clean), 32'(m_clean));
    chk("model_rise",  32'(sw_if.sw_rise),  32'(m_rise));
    chk("model_fall",  32'(sw_if.sw_fall),  32'(m_fall));
    chk("model_mask",  32'(sw_if.event_mask), 32'(m_mask));
    chk("model_pend",  32'(sw_if.change_pending), 32'(m_pend));
  endtask

  typedef struct {
    logic [W-1:0] raw;
    logic         ack;
    logic [W-1:0] clean;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] mask;
    logic         pend;
  } vec_t;

  function automatic vec_t v(input logic [W-1:0] raw, input logic ack, input logic [W-1:0] clean,
                             input logic [W-1:0] rise, input logic [W-1:0] fall,
                             input logic [W-1:0] mask, input logic pend);
    vec_t t;
    t.raw = raw; t.ack = ack; t.clean = clean; t.rise = rise;
    t.fall = fall; t.mask = mask; t.pend = pend;
    return t;
  endfunction

  vec_t tbl[$];

  initial begin
    logic [W-1:0] raw;
    logic [31:0]  acc;
    int           rises, falls;
    int           hold [W];

    sw_if.sw_raw     = '0;
    sw_if.change_ack = 1'b0;

    // Reset held, then idle: everything stays low.
    for (int j = 0; j < 3; j++) tick('0, 1'b0, 1'b1);
    for (int j = 0; j < 20; j++) begin
      tick('0, 1'b0, 1'b0);
      chk("idle_all", 32'(sw_if.sw_clean | sw_if.sw_rise | sw_if.sw_fall | sw_if.event_mask) |
          32'(sw_if.change_pending), 32'd0);
    end

    // Bit0 rise and ack; bit1 rise; bit0 fall then bit1 fall colliding with an ack.
    tbl.push_back(v(5'b00001, 0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 0));
    tbl.push_back(v(5'b00001, 0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 0));
    tbl.push_back(v(5'b00001, 0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 0));
    tbl.push_back(v(5'b00001, 0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 0));
    tbl.push_back(v(5'b00001, 0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 0));
    tbl.push_back(v(5'b00001, 0, 5'b00001, 5'b00001, 5'b00000, 5'b00001, 1));
    tbl.push_back(v(5'b00001, 0, 5'b00001, 5'b00000, 5'b00000, 5'b00001, 1));
    tbl.push_back(v(5'b00001, 0, 5'b00001, 5'b00000, 5'b00000, 5'b00001, 1));
    tbl.push_back(v(5'b00001, 1, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 0));
    tbl.push_back(v(5'b00001, 0, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 0));
    for (int j = 0; j < 5; j++)
      tbl.push_back(v(5'b00011, 0, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 0));
    tbl.push_back(v(5'b00011, 0, 5'b00011, 5'b00010, 5'b00000, 5'b00010, 1));
    tbl.push_back(v(5'b00011, 1, 5'b00011, 5'b00000, 5'b00000, 5'b00000, 0));
    tbl.push_back(v(5'b00010, 0, 5'b00011, 5'b00000, 5'b00000, 5'b00000, 0));
    tbl.push_back(v(5'b00010, 0, 5'b00011, 5'b00000, 5'b00000, 5'b00000, 0));
    tbl.push_back(v(5'b00000, 0, 5'b00011, 5'b00000, 5'b00000, 5'b00000, 0));
    tbl.push_back(v(5'b00000, 0, 5'b00011, 5'b00000, 5'b00000, 5'b00000, 0));
    tbl.push_back(v(5'b00000, 0, 5'b00011, 5'b00000, 5'b00000, 5'b00000, 0));
    tbl.push_back(v(5'b00000, 0, 5'b00010, 5'b00000, 5'b00001, 5'b00001, 1));
    tbl.push_back(v(5'b00000, 0, 5'b00010, 5'b00000, 5'b00000, 5'b00001, 1));
    tbl.push_back(v(5'b00000, 1, 5'b00000, 5'b00000, 5'b00010, 5'b00010, 1));
    tbl.push_back(v(5'b00000, 1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 0));
    tbl.push_back(v(5'b00000, 0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 0));

    foreach (tbl[j]) begin
      tick(tbl[j].raw, tbl[j].ack, 1'b0);
      chk($sformatf("vec%0d_clean", j), 32'(sw_if.sw_clean), 32'(tbl[j].clean));
      chk($sformatf("vec%0d_rise", j),  32'(sw_if.sw_rise),  32'(tbl[j].rise));
      chk($sformatf("vec%0d_fall", j),  32'(sw_if.sw_fall),  32'(tbl[j].fall));
      chk($sformatf("vec%0d_mask", j),  32'(sw_if.event_mask), 32'(tbl[j].mask));
      chk($sformatf("vec%0d_pend", j),  32'(sw_if.change_pending), 32'(tbl[j].pend));
    end

    // Glitch of 3 cycles on bit2 is swallowed.
    acc = '0;
    for (int j = 0; j < 15; j++) begin
      tick((j < 3) ? 5'b00100 : 5'b00000, 1'b0, 1'b0);
      acc |= 32'(sw_if.sw_clean | sw_if.sw_rise | sw_if.event_mask);
    end
    chk("glitch3_quiet", acc, 32'd0);

    // A 4-cycle pulse on bit2 is accepted exactly once, then released.
    rises = 0; falls = 0;
    for (int j = 0; j < 16; j++) begin
      tick((j < 4) ? 5'b00100 : 5'b00000, 1'b0, 1'b0);
      rises += int'(sw_if.sw_rise[2]);
      falls += int'(sw_if.sw_fall[2]);
      if (j == 4) chk("pulse4_clean_e4", 32'(sw_if.sw_clean[2]), 32'd0);
      if (j == 5) chk("pulse4_clean_e5", 32'(sw_if.sw_clean[2]), 32'd1);
    end
    chk("pulse4_rises", 32'(rises), 32'd1);
    chk("pulse4_falls", 32'(falls), 32'd1);

    // Chattering bit4 (2-cycle half period) never gets through.
    tick('0, 1'b1, 1'b0);
    acc = '0;
    for (int j = 0; j < 40; j++) begin
      raw = '0;
      if (j < 30) raw[4] = 1'(((j / 2) % 2));
      tick(raw, 1'b0, 1'b0);
      acc |= 32'(sw_if.sw_clean | sw_if.sw_rise | sw_if.sw_fall | sw_if.event_mask);
    end
    chk("chatter_quiet", acc, 32'd0);

    // Reset mid-count on bit3 discards progress; count restarts from the release edge.
    for (int j = 0; j < 3; j++) tick(5'b01000, 1'b0, 1'b0);
    tick(5'b01000, 1'b0, 1'b1);
    chk("rst_mid_clean", 32'(sw_if.sw_clean), 32'd0);
    chk("rst_mid_pend", 32'(sw_if.change_pending), 32'd0);
    rises = 0;
    for (int j = 0; j < 10; j++) begin
      tick(5'b01000, 1'b0, 1'b0);
      rises += int'(sw_if.sw_rise[3]);
      chk($sformatf("rst_r%0d_clean3", j), 32'(sw_if.sw_clean[3]), (j >= 5) ? 32'd1 : 32'd0);
      chk($sformatf("rst_r%0d_rise3", j),  32'(sw_if.sw_rise[3]),  (j == 5) ? 32'd1 : 32'd0);
    end
    chk("rst_rises", 32'(rises), 32'd1);

    // Randomized pin activity with random acks and occasional resets.
    raw = 5'b01000;
    for (int i = 0; i < W; i++) hold[i] = $urandom_range(1, 7);
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < W; i++) begin
        if (hold[i] == 0) begin
          raw[i]  = ~raw[i];
          hold[i] = $urandom_range(1, 7);
        end else begin
          hold[i]--;
        end
      end
      tick(raw, ($urandom_range(0, 3) == 0), ($urandom_range(0, 199) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
